// File: rtl/divider_pkg.sv
// Shared types and limits for the restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/divider_param_div_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             dvd_bit_i,
    output logic [WIDTH-1:0] prem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {prem_i, dvd_bit_i};
    assign diff    = shifted - {1'b0, dvs_i};

    // The extra top bit of the difference is the borrow: set means the divisor did not fit.
    assign qbit_o = ~diff[WIDTH];
    assign prem_o = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider_param.sv
// Multi-cycle restoring divider, one quotient bit per cycle (IDLE -> CALC -> DONE).
// Define DIVIDER_SIGNED_EN to add the signed_op port and truncating two's-complement mode.
module divider_param
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_prem;
    logic               step_qbit;
    logic [WIDTH-1:0]   dvd_nxt;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

`ifdef DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic a_neg, b_neg;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    // The core only sees magnitudes; -2^(WIDTH-1) maps to itself, which is why the
    // overflow case falls out as quo = -2^(WIDTH-1) without special handling.
    assign a_neg   = signed_op & a[WIDTH-1];
    assign b_neg   = signed_op & b[WIDTH-1];
    assign a_mag   = cond_neg(a, a_neg);
    assign b_mag   = cond_neg(b, b_neg);
    assign quo_fin = cond_neg(dvd_nxt, qneg_q);
    assign rem_fin = cond_neg(step_prem, rneg_q);
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign quo_fin = dvd_nxt;
    assign rem_fin = step_prem;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem_i    (prem_q),
        .dvs_i     (dvs_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .prem_o    (step_prem),
        .qbit_o    (step_qbit)
    );

    // Dividend register shifts left; quotient bits fill in from the bottom.
    assign dvd_nxt = {dvd_q[WIDTH-2:0], step_qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = a;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        prem_d  = '0;
`ifdef DIVIDER_SIGNED_EN
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
`endif
                    end
                end
            end
            CALC: begin
                dvd_d  = dvd_nxt;
                prem_d = step_prem;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = quo_fin;
                    rem_d   = rem_fin;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    // Working registers are only meaningful in CALC, so they carry no reset.
    always_ff @(posedge clk) begin
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        prem_q <= prem_d;
    end

    assign busy        = (state_q != IDLE);
    assign finish      = (state_q == DONE);
    assign quo         = quo_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/divider_param.md
DIVIDER_PARAM -- requirements
Module: divider_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width (legal range 4..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a division, sampled high on a clk edge while in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: dividend, captured on the accepting edge.
REQ-006 SHALL have port b, input, WIDTH bits: divisor, captured on the accepting edge.
REQ-007 SHALL have port signed_op, input, 1 bit: two's-complement mode, captured on the accepting edge; present only when DIVIDER_SIGNED_EN is defined.
REQ-008 SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-009 SHALL have port finish, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-010 SHALL have port quo, output, WIDTH bits: quotient.
REQ-011 SHALL have port rem, output, WIDTH bits: remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: high when the last division had b == 0.

Function
REQ-013 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-014 In IDLE with start=1 and b!=0, SHALL latch operands and move to CALC with step counter = WIDTH-1.
REQ-015 SHALL perform one restoring shift-subtract step per cycle in CALC, WIDTH steps total, then move to DONE.
REQ-016 SHALL assert finish exactly WIDTH+1 rising edges after the accepting edge.
REQ-017 In IDLE with start=1 and b==0, SHALL move directly to DONE, giving finish 1 edge after acceptance, with quo = all ones, rem = a, div_by_zero = 1.
REQ-018 SHALL ignore start in CALC and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-019 SHALL update quo, rem and div_by_zero only on the DONE entry edge and hold them through IDLE until the next DONE.
REQ-020 SHALL accept start again on the edge immediately after DONE (back-to-back operation, WIDTH+2 cycles per op).
REQ-021 In unsigned mode, SHALL satisfy a == quo*b + rem, with rem < b.

Reset
REQ-022 With rst_n=0 on a clk edge, SHALL force state IDLE and busy=0, finish=0, quo=0, rem=0, div_by_zero=0, counter=0, including mid-CALC (the operation is discarded, no finish).
REQ-023 If rst_n=0 and start=1 on the same edge, reset SHALL win.

Configuration
REQ-024 With DIVIDER_SIGNED_EN defined and signed_op=1, SHALL divide magnitudes, negate quo if the operand signs differ, and give rem the sign of a (truncating division).
REQ-025 With DIVIDER_SIGNED_EN defined, SHALL produce the signed overflow case (-2^(WIDTH-1)) / -1 as quo = -2^(WIDTH-1), rem = 0, div_by_zero = 0, with unchanged latency.
REQ-026 With DIVIDER_SIGNED_EN undefined, SHALL omit the signed_op port and all sign logic, making every operation unsigned.

Structure
REQ-027 Package divider_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the localparam width limits.
REQ-028 SHALL instantiate one sub-module div_step: a combinational single restoring step (partial remainder, divisor in; next partial remainder, quotient bit out).

Verification (WIDTH=32)
REQ-029 Bench SHALL check: a=351, b=23, start pulse -> finish at +33 edges, quo=15, rem=6.
REQ-030 Bench SHALL check: a=3, b=3 -> quo=1, rem=0; then a=0x7FFFFFFF, b=0x7FFFFFFF -> quo=1, rem=0.
REQ-031 Bench SHALL check: a=0xFFFFFFFF, b=0xFFFFFFFF, with a and b changed to 5 and 0 during CALC -> quo=1, rem=0, div_by_zero=0.
REQ-032 Bench SHALL check: a=100, b=0 -> finish after 1 edge, quo=0xFFFFFFFF, rem=100, div_by_zero=1.
REQ-033 Bench SHALL check: rst_n=0 at step 10 of a=351/b=23 -> no finish, outputs 0; a following 3/3 op -> quo=1, rem=0.
REQ-034 Bench SHALL check, with DIVIDER_SIGNED_EN: signed_op=1, a=-7, b=2 -> quo=-3, rem=-1; a=0x80000000, b=-1 -> quo=0x80000000, rem=0.
